cp0_unit: RTL
=============

# cp0_unit

Coprocessor-0 exception/interrupt controller for the 5-stage MIPS pipeline. Sits at the M stage. It samples the victim instruction's PC, delay-slot flag and exception code, together with the six hardware interrupt lines. It raises `req`, the flush/redirect request that every pipeline register consumes to clear itself and load the handler PC 32'h0000_4180. It also holds SR, Cause, EPC and PRId for `mfc0`/`mtc0`/`eret`.

## Interface
- `PRID`, default 32'h2023_0007: read-only PRId value.
- `clk` input 1: clock.
- `reset` input 1: synchronous, active-high.
- `we` input 1: `mtc0` write enable, from M stage.
- `addr` input 5: CP0 register number for read and write.
- `wdata` input 32: `mtc0` data.
- `rdata` output 32: `mfc0` data, combinational.
- `vpc` input 32: PC of the M-stage instruction.
- `bd_in` input 1: M-stage instruction sits in a delay slot.
- `exc_in` input 5: accumulated exception code of the M-stage instruction; 0 means none.
- `hw_int` input 6: external interrupt lines, level-sensitive.
- `eret` input 1: M-stage instruction is `eret`.
- `req` output 1: exception/interrupt taken this cycle, combinational.
- `epc_out` output 32: current EPC, the `eret` target.

## Operation
- Registers and writable bits:
  - SR (12): IM[15:10], EXL[1], IE[0]. All other bits read 0.
  - Cause (13): BD[31], IP[15:10], ExcCode[6:2]. All other bits read 0. Cause is not writable by `mtc0`.
  - EPC (14): full 32 bits.
  - PRId (15): constant `PRID`.
- Any other address reads 0. A write to any other address is ignored.
- `int_req = |(hw_int & SR.IM) & SR.IE & ~SR.EXL`.
- `exc_req = (exc_in != 0) & ~SR.EXL`.
- `req = int_req | exc_req`.
- When both are asserted, the interrupt has priority and ExcCode is recorded as 0.
- On a clock edge with `req`=1:
  - SR.EXL <= 1.
  - Cause.BD <= `bd_in`.
  - Cause.ExcCode <= `int_req` ? 0 : `exc_in`.
  - EPC <= `bd_in` ? `vpc`-4 : `vpc`, with 32-bit wrap.
  - Any `mtc0` and `eret` in the same cycle are discarded.
- On a clock edge with `req`=0 and `eret`=1: SR.EXL <= 0.
- On a clock edge with `req`=0 and `we`=1: write the addressed register through its mask.
- Cause.IP <= `hw_int` on every clock edge, independent of `req`, `we` and `eret`.
- Read data for Cause shows the registered IP, so it lags `hw_int` by one cycle.
- `rdata` has no bypass: an `mfc0` in the same cycle as an `mtc0` to the same register returns the old value.

## Timing
- Reset: all SR, Cause and EPC bits are 0 after the reset edge.
  - As a result, `req`=0, `epc_out`=0, and `rdata` = 0 for addresses 12/13/14.
  - `reset` overrides `req`, `we`, `eret` and `hw_int` sampling in the same cycle.
- `req` is combinational from `exc_in`, `hw_int` and registered SR, with zero cycle latency. Pipeline registers consume it at the same edge at which CP0 commits its state.
- The EXL set by a taken request masks all further requests starting from the next cycle.
- `eret` clearing EXL re-enables requests from the next cycle. A pending interrupt is therefore taken on the first cycle after `eret`.
- `mtc0` to SR takes effect on `req` from the next cycle.
- `epc_out` reflects an `mtc0` to EPC from the next cycle.
- `req` is a single-cycle pulse per event, because EXL is set at the same edge.
- A level interrupt still asserted after `eret` produces `req` again.

## Structure
- Shared package `cp0_pkg` holds:
  - register numbers: `CP0_SR`=12, `CP0_CAUSE`=13, `CP0_EPC`=14, `CP0_PRID`=15.
  - bit positions for IM, EXL, IE, BD, IP and ExcCode.
  - ExcCode constants: Int=0, AdEL=4, AdES=5, Syscall=8, RI=10, Ov=12.
  - `HANDLER_PC` = 32'h0000_4180.
- No sub-module. The block is flat: three registers, a request decode and a read mux.

## Test plan
- Reset, then read 12/13/14/15: `rdata` = 0, 0, 0, `PRID`; `req`=0.
- `mtc0` SR <= 32'h0000_0401, then `hw_int`=6'b000001: `req`=1 on that cycle. Next cycle: Cause=32'h0000_0400, EXL=1, EPC=`vpc`, `req`=0.
- `exc_in`=10 (RI), `bd_in`=1, `vpc`=32'h0000_3008: `req`=1. Then EPC=32'h0000_3004, Cause=32'h8000_0028.
- `exc_in`=12 and an enabled `hw_int`[2] in the same cycle: Cause.ExcCode=0, Cause.IP[12] set, EPC=`vpc`.
- EXL=1, `exc_in`=4: `req`=0 and no state change. Then `eret`: EXL=0; a level interrupt still asserted gives `req`=1 the next cycle.
- `we`=1 to EPC together with `exc_in`=8: the exception wins, EPC=`vpc`, and the `mtc0` data is dropped.

Source files
------------

// File: rtl/cp0_pkg.sv
// cp0_pkg: CP0 register numbers, field positions, exception codes and handler address.
package cp0_pkg;
  localparam logic [4:0] CP0_SR = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC = 5'd14;
  localparam logic [4:0] CP0_PRID = 5'd15;
  localparam int IM_LO = 10;
  localparam int IM_HI = 15;
  localparam int EXL_BIT = 1;
  localparam int IE_BIT = 0;
  localparam int BD_BIT = 31;
  localparam int IP_LO = 10;
  localparam int IP_HI = 15;
  localparam int EXC_LO = 2;
  localparam int EXC_HI = 6;
  localparam logic [31:0] SR_MASK = 32'h0000_fc03;
  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
  typedef enum logic [4:0] {
    EXC_INT = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_SYSCALL = 5'd8,
    EXC_RI = 5'd10,
    EXC_OV = 5'd12
  } exc_code_e;
endpackage

// File: rtl/cp0_unit_if.sv
// cp0_unit_if: M-stage side of the CP0 block (mfc0/mtc0/eret bus, victim info, request out).
interface cp0_unit_if;
  logic        we;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [31:0] vpc;
  logic        bd_in;
  logic [4:0]  exc_in;
  logic [5:0]  hw_int;
  logic        eret;
  logic        req;
  logic [31:0] epc_out;
  modport master (output we, addr, wdata, vpc, bd_in, exc_in, hw_int, eret, input rdata, req, epc_out);
  modport slave (input we, addr, wdata, vpc, bd_in, exc_in, hw_int, eret, output rdata, req, epc_out);
endinterface

// File: rtl/cp0_unit.sv
// cp0_unit: SR/Cause/EPC/PRId with exception/interrupt request decode at the M stage.
module cp0_unit
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID = 32'h2023_0007
) (
  input logic clk,
  input logic reset,
  cp0_unit_if.slave bus
);
  logic [31:0] sr_q, sr_d, cause_q, cause_d, epc_q, epc_d;
  logic int_req, exc_req;
  assign int_req = |(bus.hw_int & sr_q[IM_HI:IM_LO]) & sr_q[IE_BIT] & ~sr_q[EXL_BIT];
  assign exc_req = (bus.exc_in != 5'd0) & ~sr_q[EXL_BIT];
  assign bus.req = int_req | exc_req;
  assign bus.epc_out = epc_q;
  assign bus.rdata = bus.addr == CP0_SR ? sr_q :
                     bus.addr == CP0_CAUSE ? cause_q :
                     bus.addr == CP0_EPC ? epc_q :
                     bus.addr == CP0_PRID ? PRID : 32'd0;
  always_comb begin
    sr_d = sr_q;
    cause_d = cause_q;
    epc_d = epc_q;
    cause_d[IP_HI:IP_LO] = bus.hw_int;
    if (bus.req) begin
      sr_d[EXL_BIT] = 1'b1;
      cause_d[BD_BIT] = bus.bd_in;
      cause_d[EXC_HI:EXC_LO] = int_req ? EXC_INT : bus.exc_in;
      epc_d = bus.bd_in ? bus.vpc - 32'd4 : bus.vpc;
    end else begin
      sr_d[EXL_BIT] = bus.eret ? 1'b0 : sr_q[EXL_BIT];
      sr_d = bus.we && bus.addr == CP0_SR ? bus.wdata & SR_MASK : sr_d;
      epc_d = bus.we && bus.addr == CP0_EPC ? bus.wdata : epc_q;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q <= '0;
      cause_q <= '0;
      epc_q <= '0;
    end else begin
      sr_q <= sr_d;
      cause_q <= cause_d;
      epc_q <= epc_d;
    end
  end
endmodule
